// File: rtl/ula_pkg.sv
// Shared encodings for the iterative ALU: opcodes, controller states and bank register indices.
package ula_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_LOAD = 3'b111;

  localparam logic [1:0] REG_A    = 2'b00;
  localparam logic [1:0] REG_B    = 2'b01;
  localparam logic [1:0] REG_ACC  = 2'b10;
  localparam logic [1:0] REG_ZERO = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALC    = 2'b01,
    ESCREVE = 2'b10,
    ERRO    = 2'b11
  } estado_t;

endpackage

// File: rtl/ula_iterativa_divisor_serial.sv
// Restoring unsigned divider, one quotient bit per cycle. The quociente/resto outputs
// show the values after the step taken this cycle, so they are final while done is high.
module divisor_serial #(
  parameter int LARGURA = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LARGURA-1:0] dividendo,
  input  logic [LARGURA-1:0] divisor,
  output logic [LARGURA-1:0] quociente,
  output logic [LARGURA-1:0] resto,
  output logic               done
);

  localparam int CW = $clog2(LARGURA);

  logic [LARGURA-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [LARGURA:0]   desloc;
  logic [LARGURA-1:0] diff, rem_passo, quo_passo;
  logic               cabe;

  always_comb begin
    desloc    = {rem_q, quo_q[LARGURA-1]};
    cabe      = desloc >= {1'b0, div_q};
    // The true difference is below the divisor, so wrapping at LARGURA bits is exact.
    diff      = desloc[LARGURA-1:0] - div_q;
    rem_passo = cabe ? diff : desloc[LARGURA-1:0];
    quo_passo = {quo_q[LARGURA-2:0], cabe};
    done      = busy_q && (cnt_q == CW'(LARGURA - 1));
    quociente = quo_passo;
    resto     = rem_passo;

    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      rem_d  = rem_passo;
      quo_d  = quo_passo;
      cnt_d  = cnt_q + 1'b1;
      busy_d = !done;
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividendo;
      div_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/ula_iterativa.sv
// Multi-cycle ALU feeding the register bank write port. Every output is a flop so the
// bank, which captures on the falling edge, never sees a glitch on Dado/Escrita.
//
// Handshake: Start is sampled only while idle (Ocupado low); the accepting edge latches
// Op/OperandoA/OperandoB. Completion is a one-cycle Pronto pulse, accompanied by a
// one-cycle Escrita pulse unless the operation was a divide by zero.
module ula_iterativa
  import ula_pkg::*;
#(
  parameter int         LARGURA    = 32,
  parameter logic [1:0] ID_DESTINO = REG_ACC
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [2:0]         Op,
  input  logic [LARGURA-1:0] OperandoA,
  input  logic [LARGURA-1:0] OperandoB,
  output logic [LARGURA-1:0] Dado,
  output logic               Escrita,
  output logic [1:0]         IdReg,
  output logic               Ocupado,
  output logic               Pronto,
  output logic               DivZero,
  output logic               Overflow,
  output estado_t            estado_dbg
);

  localparam int CW  = $clog2(LARGURA);
  localparam int MSB = LARGURA - 1;

  estado_t              state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [LARGURA-1:0]   a_q, a_d, dado_q, dado_d;
  logic [2*LARGURA-1:0] prod_q, prod_d, prod_next;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 escrita_q, escrita_d, pronto_q, pronto_d, ocupado_q, ocupado_d;
  logic                 divzero_q, divzero_d, overflow_q, overflow_d;
  logic [LARGURA:0]     soma_parcial;
  logic [LARGURA-1:0]   soma, dif, div_quo, div_rem;
  logic                 ovf_soma, ovf_dif, div_start, div_done, fim;

  divisor_serial #(.LARGURA(LARGURA)) u_divisor (
    .clk       (Clock),
    .reset     (Reset),
    .start     (div_start),
    .dividendo (OperandoA),
    .divisor   (OperandoB),
    .quociente (div_quo),
    .resto     (div_rem),
    .done      (div_done)
  );

  always_comb begin
    soma     = OperandoA + OperandoB;
    dif      = OperandoA - OperandoB;
    ovf_soma = (OperandoA[MSB] == OperandoB[MSB]) && (soma[MSB] != OperandoA[MSB]);
    ovf_dif  = (OperandoA[MSB] != OperandoB[MSB]) && (dif[MSB] != OperandoA[MSB]);

    // Shift-add step: multiplier bits sit in the low half and leave from the right.
    soma_parcial = {1'b0, prod_q[2*LARGURA-1:LARGURA]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_next    = {soma_parcial, prod_q[LARGURA-1:1]};
    fim          = (op_q == OP_MUL) ? (cnt_q == CW'(LARGURA - 1)) : div_done;

    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    dado_d     = dado_q;
    overflow_d = overflow_q;
    divzero_d  = divzero_q;
    div_start  = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (Start) begin
          op_d      = Op;
          a_d       = OperandoA;
          cnt_d     = '0;
          divzero_d = 1'b0;
          case (Op)
            OP_MUL: begin
              prod_d  = {{LARGURA{1'b0}}, OperandoB};
              state_d = CALC;
            end
            OP_DIV, OP_MOD: begin
              if (OperandoB == '0) begin
                state_d    = ERRO;
                overflow_d = 1'b0;
              end else begin
                div_start = 1'b1;
                state_d   = CALC;
              end
            end
            default: begin
              state_d    = ESCREVE;
              overflow_d = 1'b0;
              case (Op)
                OP_ADD: begin dado_d = soma;                  overflow_d = ovf_soma; end
                OP_SUB: begin dado_d = dif;                   overflow_d = ovf_dif;  end
                OP_AND: dado_d = OperandoA & OperandoB;
                OP_OR:  dado_d = OperandoA | OperandoB;
                default: dado_d = OperandoB;
              endcase
            end
          endcase
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) prod_d = prod_next;
        if (fim) begin
          state_d = ESCREVE;
          case (op_q)
            OP_MUL: begin
              dado_d     = prod_next[LARGURA-1:0];
              overflow_d = |prod_next[2*LARGURA-1:LARGURA];
            end
            OP_DIV: begin dado_d = div_quo; overflow_d = 1'b0; end
            default: begin dado_d = div_rem; overflow_d = 1'b0; end
          endcase
        end
      end
      ESCREVE: state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase

    if (state_d == ERRO) divzero_d = 1'b1;
    escrita_d = (state_d == ESCREVE);
    pronto_d  = (state_d == ESCREVE) || (state_d == ERRO);
    ocupado_d = (state_d == CALC) || (state_d == ESCREVE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= OCIOSO;
      op_q       <= OP_ADD;
      a_q        <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      dado_q     <= '0;
      escrita_q  <= 1'b0;
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      divzero_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      dado_q     <= dado_d;
      escrita_q  <= escrita_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
      divzero_q  <= divzero_d;
      overflow_q <= overflow_d;
    end
  end

  assign Dado       = dado_q;
  assign Escrita    = escrita_q;
  assign Pronto     = pronto_q;
  assign Ocupado    = ocupado_q;
  assign DivZero    = divzero_q;
  assign Overflow   = overflow_q;
  assign IdReg      = ID_DESTINO;
  assign estado_dbg = state_q;

endmodule

// File: tb/tb_ula_iterativa.sv
// Self-checking bench for ula_iterativa: directed scenarios plus randomized operations
// compared against an arithmetic reference model.
module tb_ula_iterativa;
  import ula_pkg::*;

  localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_MUL = 3'd2, T_DIV = 3'd3;
  localparam logic [2:0] T_MOD = 3'd4, T_AND = 3'd5, T_OR = 3'd6, T_LOAD = 3'd7;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [31:0] a, b, dado;
  logic        escrita, ocupado, pronto, divzero, overflow;
  logic [1:0]  idreg;
  estado_t     estado_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  ula_iterativa #(.LARGURA(32), .ID_DESTINO(2'b10)) dut (
    .Clock(clk), .Reset(reset), .Start(start), .Op(op),
    .OperandoA(a), .OperandoB(b), .Dado(dado), .Escrita(escrita),
    .IdReg(idreg), .Ocupado(ocupado), .Pronto(pronto), .DivZero(divzero),
    .Overflow(overflow), .estado_dbg(estado_dbg)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the operation definitions.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, y,
                                input logic [31:0] prev, output logic [31:0] r,
                                output logic ovf, output logic dz, output int lat);
    longint sx, sy, s;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = prev; ovf = 1'b0; dz = 1'b0; lat = 1;
    case (o)
      T_ADD: begin s = sx + sy; r = x + y; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      T_SUB: begin s = sx - sy; r = x - y; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      T_MUL: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; ovf = (p[63:32] != 0); lat = 33; end
      T_DIV: if (y == 0) dz = 1'b1; else begin r = x / y; lat = 33; end
      T_MOD: if (y == 0) dz = 1'b1; else begin r = x % y; lat = 33; end
      T_AND: r = x & y;
      T_OR:  r = x | y;
      default: r = y;
    endcase
  endfunction

  // Driver/collector: issues one op and records what the DUT did until shortly after Pronto.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y,
                        output logic [31:0] r_dado, output logic r_ovf, output logic r_dz,
                        output int n_esc, output int lat_esc, output int lat_pronto,
                        output int n_busy);
    n_esc = 0; lat_esc = -1; lat_pronto = -1; n_busy = 0;
    r_dado = '0; r_ovf = 1'b0; r_dz = 1'b0;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ocupado) n_busy++;
      if (escrita) begin n_esc++; lat_esc = c; end
      if (pronto && lat_pronto < 0) begin
        lat_pronto = c; r_dado = dado; r_ovf = overflow; r_dz = divzero;
      end
      if (lat_pronto >= 0 && c >= lat_pronto + 2) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dado, escrita, pronto, ocupado, divzero, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dado=%h esc=%b pr=%b oc=%b dz=%b ov=%b, expected all 0",
               dado, escrita, pronto, ocupado, divzero, overflow);
    end
    n_checks++;
    if (idreg !== 2'b10) begin n_fail++; $display("FAIL reset_idreg: got %b expected 10", idreg); end
    reset = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [31:0] d; logic ov, dz; int ne, le, lp, nb;
    run_op(T_ADD, 32'd5, 32'd7, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (d !== 32'd12 || ov !== 1'b0) begin n_fail++; $display("FAIL add_result: got %0d ov=%b expected 12 ov=0", d, ov); end
    n_checks++;
    if (le !== 1 || ne !== 1 || lp !== 1) begin n_fail++; $display("FAIL add_timing: got esc_lat=%0d n_esc=%0d pronto_lat=%0d expected 1 1 1", le, ne, lp); end
    n_checks++;
    if (idreg !== 2'b10) begin n_fail++; $display("FAIL add_idreg: got %b expected 10", idreg); end
    run_op(T_SUB, 32'h8000_0000, 32'd1, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (d !== 32'h7FFF_FFFF || ov !== 1'b1) begin n_fail++; $display("FAIL sub_overflow: got %h ov=%b expected 7fffffff ov=1", d, ov); end
    n_checks++;
    if (ne !== 1) begin n_fail++; $display("FAIL sub_escrita_count: got %0d expected 1", ne); end
  endtask

  task automatic test_mul();
    logic [31:0] d; logic ov, dz; int ne, le, lp, nb;
    run_op(T_MUL, 32'd7, 32'd6, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (d !== 32'd42 || ov !== 1'b0) begin n_fail++; $display("FAIL mul_result: got %0d ov=%b expected 42 ov=0", d, ov); end
    n_checks++;
    if (nb !== 33 || le !== 33 || ne !== 1) begin n_fail++; $display("FAIL mul_timing: got busy=%0d esc_lat=%0d n_esc=%0d expected 33 33 1", nb, le, ne); end
    run_op(T_MUL, 32'h1_0000, 32'h1_0000, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (d !== 32'd0 || ov !== 1'b1) begin n_fail++; $display("FAIL mul_overflow: got %h ov=%b expected 0 ov=1", d, ov); end
  endtask

  task automatic test_div_mod();
    logic [31:0] d; logic ov, dz; int ne, le, lp, nb;
    run_op(T_DIV, 32'd100, 32'd7, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (d !== 32'd14 || le !== 33) begin n_fail++; $display("FAIL div_result: got %0d lat=%0d expected 14 lat=33", d, le); end
    run_op(T_MOD, 32'd100, 32'd7, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (d !== 32'd2 || le !== 33) begin n_fail++; $display("FAIL mod_result: got %0d lat=%0d expected 2 lat=33", d, le); end
    run_op(T_DIV, 32'd9, 32'd0, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (lp !== 1 || ne !== 0) begin n_fail++; $display("FAIL divzero_timing: got pronto_lat=%0d n_esc=%0d expected 1 0", lp, ne); end
    n_checks++;
    if (dz !== 1'b1 || d !== 32'd2) begin n_fail++; $display("FAIL divzero_flag: got dz=%b dado=%0d expected dz=1 dado=2", dz, d); end
    n_checks++;
    if (divzero !== 1'b1) begin n_fail++; $display("FAIL divzero_sticky: got %b expected 1", divzero); end
    run_op(T_ADD, 32'd1, 32'd2, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (dz !== 1'b0 || d !== 32'd3) begin n_fail++; $display("FAIL divzero_clear: got dz=%b dado=%0d expected dz=0 dado=3", dz, d); end
  endtask

  task automatic test_ignored_start();
    int ne; logic [31:0] d;
    ne = 0; d = '0;
    op = T_MUL; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (escrita) begin ne++; d = dado; end
      if (c == 5) begin start = 1'b1; op = T_ADD; a = 32'd100; b = 32'd200; end
      if (c == 6) start = 1'b0;
    end
    n_checks++;
    if (ne !== 1 || d !== 32'd9) begin n_fail++; $display("FAIL ignored_start: got n_esc=%0d dado=%0d expected 1 9", ne, d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic ov, dz; int ne, le, lp, nb;
    ne = 0;
    op = T_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (escrita) ne++;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (escrita) ne++;
    n_checks++;
    if ({dado, escrita, pronto, ocupado, divzero, overflow} !== '0 || ne !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: got dado=%h esc=%b pr=%b oc=%b dz=%b ov=%b n_esc=%0d expected all 0",
               dado, escrita, pronto, ocupado, divzero, overflow, ne);
    end
    reset = 1'b0;
    run_op(T_ADD, 32'd1, 32'd1, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (d !== 32'd2 || le !== 1) begin n_fail++; $display("FAIL after_reset_add: got %0d lat=%0d expected 2 lat=1", d, le); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    logic [31:0] d5;
    pat = '0; d5 = '0;
    op = T_ADD; a = 32'd10; b = 32'd20; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      pat[c-1] = escrita;
      if (c == 5) d5 = dado;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pat !== 6'b010101 || d5 !== 32'd30) begin n_fail++; $display("FAIL back_to_back: got pattern=%b dado=%0d expected 010101 30", pat, d5); end
  endtask

  task automatic test_random();
    logic [31:0] d, x, y, er, prev; logic ov, dz, eov, edz; int ne, le, lp, nb, elat;
    logic [2:0] o;
    run_op(T_LOAD, 32'hDEAD_BEEF, 32'hCAFE_F00D, d, ov, dz, ne, le, lp, nb);
    n_checks++;
    if (d !== 32'hCAFE_F00D || ov !== 1'b0) begin n_fail++; $display("FAIL load: got %h ov=%b expected cafef00d ov=0", d, ov); end
    prev = 32'hCAFE_F00D;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      if (($urandom_range(0, 3) == 0)) y = y >> $urandom_range(16, 31);
      if ((o == T_DIV || o == T_MOD) && $urandom_range(0, 3) == 0) y = '0;
      if (o == T_MUL && y == 0) y = 32'd1;
      model(o, x, y, prev, er, eov, edz, elat);
      run_op(o, x, y, d, ov, dz, ne, le, lp, nb);
      n_checks++;
      if (d !== er || dz !== edz || lp !== elat || ne !== (edz ? 0 : 1)) begin
        n_fail++;
        $display("FAIL random_op%0d op=%0d a=%h b=%h: got dado=%h dz=%b lat=%0d n_esc=%0d expected %h %b %0d %0d",
                 i, o, x, y, d, dz, lp, ne, er, edz, elat, edz ? 0 : 1);
      end
      if (o != T_DIV && o != T_MOD) begin
        n_checks++;
        if (ov !== eov) begin n_fail++; $display("FAIL random_ovf%0d op=%0d a=%h b=%h: got %b expected %b", i, o, x, y, ov, eov); end
      end
      prev = er;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div_mod();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ula_iterativa.md
Name: ula_iterativa

Overview:
Multi-cycle arithmetic unit directly downstream of the register bank. It consumes the two read operands (accumulator and selected source) and computes the result. It then drives the bank's write-back port (`Dado`, `Escrita`, `IdReg`) so the result lands in the accumulator. Single-cycle ops: add, sub, logic, load. Iterative ops: unsigned multiply, divide and modulo (one bit per cycle), under a `Start`/`Pronto` handshake.

Parameters:
- `LARGURA`, 32, datapath width in bits.
- `ID_DESTINO`, 2'b10, register index driven on `IdReg` at write-back (accumulator).

Ports:
- `Clock` in 1: single clock; all state updates on rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Start` in 1: request to begin an operation; sampled only in OCIOSO.
- `Op` in 3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 AND, 110 OR, 111 LOAD (result = B).
- `OperandoA` in LARGURA: connects to bank `DadoLido1` (accumulator).
- `OperandoB` in LARGURA: connects to bank `DadoLido2`.
- `Dado` out LARGURA: result to bank write port.
- `Escrita` out 1: write enable to bank, one-cycle pulse.
- `IdReg` out 2: destination index to bank; constant `ID_DESTINO`.
- `Ocupado` out 1: high in CALC and ESCREVE.
- `Pronto` out 1: one-cycle pulse when operation ends (with or without write).
- `DivZero` out 1: sticky error from DIV/MOD with B = 0; cleared on next accepted Start.
- `Overflow` out 1: signed overflow (ADD/SUB) or nonzero upper product half (MUL); updated at Pronto.

Behaviour:
- Reset values:
  - State OCIOSO.
  - `Dado` = 0; `Escrita`, `Pronto`, `Ocupado`, `DivZero`, `Overflow` = 0.
  - Counter = 0.
- All outputs are registered; `IdReg` is tied to `ID_DESTINO`.
- State OCIOSO:
  - On `Start` = 1, latch `Op`, `OperandoA` and `OperandoB` into internal registers and clear `DivZero`.
  - ADD/SUB/AND/OR/LOAD go to ESCREVE.
  - MUL/DIV/MOD with B ≠ 0 go to CALC with counter = 0.
  - DIV/MOD with B = 0 go to ERRO.
- State CALC:
  - One iteration per cycle, LARGURA iterations total.
  - MUL: shift-add into a 2×LARGURA product; result is the low LARGURA bits; `Overflow` = (high half ≠ 0).
  - DIV/MOD: restoring division; result is the quotient (DIV) or remainder (MOD).
  - Go to ESCREVE after the counter reaches LARGURA-1.
- State ESCREVE: `Dado` = result, `Escrita` = 1 and `Pronto` = 1 for exactly one cycle, then go to OCIOSO.
- State ERRO: `DivZero` = 1, `Pronto` = 1 for one cycle, `Escrita` = 0, `Dado` unchanged, then go to OCIOSO.
- Latency, from the edge that samples `Start` to the cycle where `Escrita` is high:
  - 1 cycle for single-cycle ops.
  - LARGURA+1 cycles for MUL/DIV/MOD.
  - `Pronto` for a divide by zero also arrives 1 cycle after Start.
- The bank captures on the falling edge. `Escrita` and `Dado` must be stable for the full high cycle, so no combinational glitching on these outputs.
- Arithmetic: ADD/SUB wrap modulo 2^LARGURA; `Overflow` is the signed two's-complement overflow. AND/OR/LOAD force `Overflow` = 0.
- `Start` while `Ocupado` = 1 is ignored: no queueing, and latched operands are unaffected.
- Operand inputs may change freely after the Start edge; only latched copies are used.
- `Reset` asserted mid-operation: return to OCIOSO on that edge, all outputs to reset values, no `Escrita` pulse issued.
- `Start` held high continuously: a new op is accepted on the first cycle back in OCIOSO. The back-to-back spacing is therefore 2 cycles for single-cycle ops.

Decomposition:
- Shared package `ula_pkg`:
  - Op encoding constants (OP_ADD … OP_LOAD).
  - State enumeration (OCIOSO, CALC, ESCREVE, ERRO).
  - Register index constants (REG_A = 2'b00, REG_B = 2'b01, REG_ACC = 2'b10, REG_ZERO = 2'b11).
- One sub-module, `divisor_serial`: restoring divider holding remainder/quotient/counter, with its own start/done. MUL stays inline in the top.

Test Plan:
- Reset then ADD: A = 5, B = 7, Start 1 cycle -> next cycle Escrita = 1, Dado = 12, IdReg = 2'b10, Pronto = 1, Overflow = 0.
- SUB overflow: A = 32'h8000_0000, B = 1 -> Dado = 32'h7FFF_FFFF, Overflow = 1, Escrita one cycle.
- MUL: A = 7, B = 6 -> Ocupado high 33 cycles, Escrita exactly at cycle 33, Dado = 42, Overflow = 0. Then A = 32'h1_0000, B = 32'h1_0000 -> Dado = 0, Overflow = 1.
- DIV/MOD: A = 100, B = 7 -> DIV gives Dado = 14, MOD gives Dado = 2. A = 9, B = 0 -> Pronto after 1 cycle, Escrita never asserted, DivZero = 1, Dado retains prior value.
- Start pulsed during CALC of MUL 3×3 with different operands -> ignored; result 9, only one Escrita pulse.
- Reset asserted at cycle 10 of a DIV -> next cycle all outputs 0, no Escrita. A following ADD 1+1 gives Dado = 2 normally.
